vx_commit_counters: RTL
=======================

// Module: vx_commit_counters
// PURPOSE
//  Consumes the per-cycle retire summary (valid + popcount of committed thread lanes) from the commit stage.
//  Maintains the 64-bit machine counters mcycle, minstret and (optionally) an idle-cycle counter, plus mcountinhibit.
//  Serves CSR reads/writes from the CSR unit.
//  Sits between the commit stage's cmt_to_csr output and the CSR data path.
// PARAMETERS
//  CORE_ID      0   core index, used only in trace messages
//  NUM_LANES    24  max lanes retiring per cycle (units x NUM_THREADS); sets CSW=$clog2(NUM_LANES+1)
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous, active-high reset
//  cmt_valid        in   1    retire summary valid this cycle
//  cmt_size         in   CSW  lanes retired this cycle (0..NUM_LANES)
//  csr_rd_addr      in   12   CSR read address
//  csr_rd_data      out  32   read data, combinational from current register state
//  csr_rd_hit       out  1    csr_rd_addr maps to a register in this block
//  csr_wr_valid     in   1    CSR write strobe
//  csr_wr_addr      in   12   CSR write address
//  csr_wr_data      in   32   CSR write data
//  instret          out  64   current minstret value
//  cycles           out  64   current mcycle value
// BEHAVIOUR
//  Reset: mcycle=0, minstret=0, idle=0, mcountinhibit=0; outputs follow (rd_data=0 only if addr unmapped).
//  Address map: MCYCLE 0xB00 / MCYCLEH 0xB80; MINSTRET 0xB02 / MINSTRETH 0xB82; MCOUNTINHIBIT 0x320
//    (only bit0 CY, bit2 IR writable, other bits read 0).
//  Unmapped read: rd_hit=0, rd_data=0. Unmapped write: ignored.
//  Per cycle, when not inhibited:
//    mcycle += 1.
//    minstret += cmt_valid ? cmt_size : 0 (zero-extended to 64b).
//  Inhibit: inh[0]=1 freezes mcycle; inh[2]=1 freezes minstret. Writes to a frozen counter still take effect.
//  Arithmetic: all counters 64b modular; 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0, no sticky flag.
//  Write latency 1: value visible on reads in the cycle after csr_wr_valid.
//    Low-half write:  ctr <= {ctr[63:32], wdata}.
//    High-half write: ctr <= {wdata, ctr[31:0]}.
//    The written counter's increment in that cycle is dropped (write wins entirely).
//    Other counters increment normally.
//  No carry from low to high in the write cycle.
//  Write to MCOUNTINHIBIT takes effect for the increment of the following cycle, not the write cycle.
//  Read/write same address same cycle: read returns old value.
//  cmt_valid=0: cmt_size ignored even if nonzero.
//  Reset mid-operation: all state clears next edge, pending write discarded.
//  cmt_size > NUM_LANES: added as given; simulation assertion fires.
//  No handshake back-pressure: block always accepts; cmt_valid is a one-cycle pulse per retire group.
// CONFIGURATION
//  VX_COMMIT_IDLE_CNT_EN defined:
//    Adds a 64-bit idle counter (mhpmcounter3: 0xB03 / 0xB83).
//    Increments each cycle with cmt_valid=0 or cmt_size=0.
//    Gated by inh[0]; same write rules as the other counters.
//  VX_COMMIT_IDLE_CNT_EN undefined:
//    No idle register; 0xB03 and 0xB83 are unmapped (rd_hit=0, rd_data=0).
// TESTING
//  T1: reset, 10 idle cycles -> cycles=10, instret=0, read 0xB00=10, rd_hit=1.
//  T2: cmt_valid=1 with size 4,0,24 on consecutive cycles -> instret +28 after 3 cycles.
//      With IDLE_EN, idle +1 for the size-0 cycle.
//  T3: preload minstret via 0xB02=0xFFFF_FFFF, 0xB82=0xFFFF_FFFF; then commit size 3 -> instret=2.
//  T4: write 0xB00=0x100 in a cycle with cmt_valid=1/size=5 -> next cycle mcycle=0x100.
//      In the same cycle, minstret +5.
//  T5: MCOUNTINHIBIT=0x5, run 8 cycles with size=2 -> both counters frozen.
//      Write 0 -> counting resumes the cycle after.
//  T6: assert reset mid-run with a write pending -> all counters 0 next cycle; read of 0x7C0 -> rd_hit=0, data=0.

Source files
------------

// File: rtl/vx_commit_counters.sv
// Machine counters (mcycle, minstret, optional idle counter) and mcountinhibit fed by the commit retire summary.
// Define VX_COMMIT_IDLE_CNT_EN to add the idle-cycle counter at mhpmcounter3 (0xB03 / 0xB83).
module vx_commit_counters #(
   parameter int CORE_ID   = 0,
   parameter int NUM_LANES = 24,
   localparam int CSW      = $clog2(NUM_LANES + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmt_valid,
   input  logic [CSW-1:0]  cmt_size,
   input  logic [11:0]     csr_rd_addr,
   output logic [31:0]     csr_rd_data,
   output logic            csr_rd_hit,
   input  logic            csr_wr_valid,
   input  logic [11:0]     csr_wr_addr,
   input  logic [31:0]     csr_wr_data,
   output logic [63:0]     instret,
   output logic [63:0]     cycles
);

   localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic        inh_cy;
   logic        inh_ir;
   logic [63:0] retire_add;

   logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi, wr_inhibit;

   assign wr_mcycle_lo   = csr_wr_valid && (csr_wr_addr == ADDR_MCYCLE);
   assign wr_mcycle_hi   = csr_wr_valid && (csr_wr_addr == ADDR_MCYCLEH);
   assign wr_minstret_lo = csr_wr_valid && (csr_wr_addr == ADDR_MINSTRET);
   assign wr_minstret_hi = csr_wr_valid && (csr_wr_addr == ADDR_MINSTRETH);
   assign wr_inhibit     = csr_wr_valid && (csr_wr_addr == ADDR_MCOUNTINHIBIT);

   // cmt_size is ignored entirely when the summary is not valid
   assign retire_add = cmt_valid ? {{(64-CSW){1'b0}}, cmt_size} : 64'd0;

   // A write to a counter replaces that cycle's increment; inhibit updates apply from the next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         mcycle   <= 64'd0;
         minstret <= 64'd0;
         inh_cy   <= 1'b0;
         inh_ir   <= 1'b0;
      end else begin
         if (wr_mcycle_lo)
            mcycle <= {mcycle[63:32], csr_wr_data};
         else if (wr_mcycle_hi)
            mcycle <= {csr_wr_data, mcycle[31:0]};
         else if (!inh_cy)
            mcycle <= mcycle + 64'd1;

         if (wr_minstret_lo)
            minstret <= {minstret[63:32], csr_wr_data};
         else if (wr_minstret_hi)
            minstret <= {csr_wr_data, minstret[31:0]};
         else if (!inh_ir)
            minstret <= minstret + retire_add;

         if (wr_inhibit) begin
            inh_cy <= csr_wr_data[0];
            inh_ir <= csr_wr_data[2];
         end
      end
   end

`ifdef VX_COMMIT_IDLE_CNT_EN
   localparam logic [11:0] ADDR_MHPM3  = 12'hB03;
   localparam logic [11:0] ADDR_MHPM3H = 12'hB83;

   logic [63:0] idle_cnt;
   logic        wr_idle_lo, wr_idle_hi, idle_cycle;

   assign wr_idle_lo = csr_wr_valid && (csr_wr_addr == ADDR_MHPM3);
   assign wr_idle_hi = csr_wr_valid && (csr_wr_addr == ADDR_MHPM3H);
   assign idle_cycle = !cmt_valid || (cmt_size == '0);

   always_ff @(posedge clk) begin
      if (reset)
         idle_cnt <= 64'd0;
      else if (wr_idle_lo)
         idle_cnt <= {idle_cnt[63:32], csr_wr_data};
      else if (wr_idle_hi)
         idle_cnt <= {csr_wr_data, idle_cnt[31:0]};
      else if (!inh_cy && idle_cycle)
         idle_cnt <= idle_cnt + 64'd1;
   end
`endif

   always_comb begin
      csr_rd_data = 32'd0;
      csr_rd_hit  = 1'b1;
      case (csr_rd_addr)
         ADDR_MCYCLE:        csr_rd_data = mcycle[31:0];
         ADDR_MCYCLEH:       csr_rd_data = mcycle[63:32];
         ADDR_MINSTRET:      csr_rd_data = minstret[31:0];
         ADDR_MINSTRETH:     csr_rd_data = minstret[63:32];
         ADDR_MCOUNTINHIBIT: csr_rd_data = {29'd0, inh_ir, 1'b0, inh_cy};
`ifdef VX_COMMIT_IDLE_CNT_EN
         ADDR_MHPM3:         csr_rd_data = idle_cnt[31:0];
         ADDR_MHPM3H:        csr_rd_data = idle_cnt[63:32];
`endif
         default:            csr_rd_hit  = 1'b0;
      endcase
   end

   assign instret = minstret;
   assign cycles  = mcycle;

   // Oversized retire groups are still accumulated; this only flags them in simulation
   a_cmt_size_range : assert property (@(posedge clk) disable iff (reset)
      cmt_valid |-> (cmt_size <= CSW'(NUM_LANES)))
      else $error("core %0d: cmt_size %0d exceeds NUM_LANES %0d", CORE_ID, cmt_size, NUM_LANES);

endmodule
